// File: rtl/word_tx.sv
// word_tx: UART 8N1 serialiser for a strobed word of up to four bytes.
// Bytes leave least-significant first; rdy_o paces the upstream FSM.
module word_tx #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       width_i,
  output logic             rdy_o,
  output logic             tx_o
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_nxt;
  logic [2:0]        r_bytes;
  logic [2:0]        w_bytes_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              r_rdy;
  logic              w_rdy_nxt;

  logic              w_bit_end;
  logic [2:0]        w_width_clamped;
  logic [2:0]        w_bytes_dec;
  logic [WIDTH-1:0]  w_shift_dn;

  assign w_bit_end       = (r_baud == BAUD_LAST);
  assign w_width_clamped = (width_i > 3'd4) ? 3'd4 : width_i;
  assign w_bytes_dec     = r_bytes - 3'd1;
  assign w_shift_dn      = {1'b0, r_shift[WIDTH-1:1]};

  // Next-state, counter and output-register logic for the frame sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_bytes_nxt = r_bytes;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_rdy_nxt   = r_rdy;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = BAUD_ZERO;
        w_bit_nxt  = 3'd0;
        if (stb_i) begin
          w_shift_nxt = data_i;
          w_bytes_nxt = w_width_clamped;
          if (w_width_clamped != 3'd0) begin
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
            w_rdy_nxt   = 1'b0;
          end else begin
            w_tx_nxt  = 1'b1;
            w_rdy_nxt = 1'b1;
          end
        end else begin
          w_tx_nxt  = 1'b1;
          w_rdy_nxt = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = BAUD_ZERO;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end

      // Shifting on every data boundary, including the last, leaves the next
      // byte in the low bits by the time the stop bit ends.
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = BAUD_ZERO;
          w_shift_nxt = w_shift_dn;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt  = BAUD_ZERO;
          w_bytes_nxt = w_bytes_dec;
          if (w_bytes_dec != 3'd0) begin
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
            w_rdy_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = BAUD_ZERO;
        w_bit_nxt   = 3'd0;
        w_bytes_nxt = 3'd0;
        w_tx_nxt    = 1'b1;
        w_rdy_nxt   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_baud  <= BAUD_ZERO;
      r_bit   <= 3'd0;
      r_bytes <= 3'd0;
      r_shift <= {WIDTH{1'b0}};
      r_tx    <= 1'b1;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_bytes <= w_bytes_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  assign tx_o  = r_tx;
  assign rdy_o = r_rdy;

  word_tx_chk #(
    .BAUD_W   (BAUD_W),
    .BAUD_LAST(BAUD_LAST)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .state_i(r_state),
    .baud_i (r_baud),
    .bytes_i(r_bytes),
    .rdy_i  (r_rdy),
    .tx_i   (r_tx)
  );

endmodule

// word_tx_chk: structural invariants of the word_tx sequencer.
module word_tx_chk #(
  parameter int                BAUD_W    = 1,
  parameter logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(1)
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [1:0]        state_i,
  input logic [BAUD_W-1:0] baud_i,
  input logic [2:0]        bytes_i,
  input logic              rdy_i,
  input logic              tx_i
);

  a_baud_range: assert property (@(posedge clk_i) disable iff (rst_i)
    baud_i <= BAUD_LAST);

  a_bytes_range: assert property (@(posedge clk_i) disable iff (rst_i)
    bytes_i <= 3'd4);

  a_rdy_only_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    rdy_i == (state_i == 2'd0));

  a_idle_line_high: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_i == 2'd0) |-> tx_i);

endmodule

// File: tb/tb_word_tx.sv
// tb_word_tx: scoreboard bench for word_tx; a per-cycle line monitor checks
// every expected frame bit-exactly and every busy window's length.
module tb_word_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [31:0] data;
  logic [2:0]  width;
  logic        rdy;
  logic        tx;

  word_tx #(.WIDTH(32), .CLKS_PER_BIT(C)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .stb_i  (stb),
    .data_i (data),
    .width_i(width),
    .rdy_o  (rdy),
    .tx_o   (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         contig;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   dur_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line monitor: decodes frames cycle by cycle against the expected queue
  exp_t cur;
  bit   mon_active  = 1'b0;
  bit   mon_bogus   = 1'b0;
  bit   want_contig = 1'b0;
  int   mon_cnt     = 0;
  int   mon_err     = 0;
  int   rdy_run     = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active  = 1'b0;
      want_contig = 1'b0;
      rdy_run     = 0;
      exp_q.delete();
      dur_q.delete();
    end else begin
      if (!mon_active) begin
        if (want_contig) check("inter_byte_gap", tx, 1'b0);
        want_contig = 1'b0;
        if (tx == 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          mon_err    = 0;
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            mon_bogus = 1'b0;
            cur = exp_q.pop_front();
            if (!cur.contig) check("start_cycle", cyc, cur.start);
          end else begin
            mon_bogus = 1'b1;
          end
        end
      end
      if (mon_active) begin
        int  j;
        logic ebit;
        j = mon_cnt / C;
        if (j == 0)      ebit = 1'b0;
        else if (j == 9) ebit = 1'b1;
        else             ebit = cur.d[j-1];
        if (!mon_bogus && (tx !== ebit)) mon_err++;
        mon_cnt++;
        if (mon_cnt == 10 * C) begin
          mon_active = 1'b0;
          if (!mon_bogus) check($sformatf("frame_%02h_bad_samples", cur.d), mon_err, 0);
          want_contig = (exp_q.size() > 0) && exp_q[0].contig;
        end
      end
      if (rdy == 1'b0) begin
        rdy_run++;
      end else if (rdy_run > 0) begin
        check("rdy_low_cycles", rdy_run, (dur_q.size() > 0) ? dur_q[0] : 0);
        if (dur_q.size() > 0) void'(dur_q.pop_front());
        rdy_run = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while ((rdy !== 1'b1) && (k < 2000)) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // Issue one word; expectations are derived from the byte-level rules
  task automatic send(input logic [31:0] d, input logic [2:0] w);
    int n;
    wait_rdy();
    check("rdy_before_strobe", rdy, 1'b1);
    n = (w > 3'd4) ? 4 : int'(w);
    for (int b = 0; b < n; b++) begin
      exp_t e;
      e.d      = d[8*b +: 8];
      e.contig = (b != 0);
      e.start  = cyc + 1;
      exp_q.push_back(e);
    end
    if (n > 0) dur_q.push_back(10 * n * C);
    stb   = 1'b1;
    data  = d;
    width = w;
    @(posedge clk);
    #1;
    stb   = 1'b0;
    data  = $urandom;
    width = 3'($urandom);
    check("rdy_after_strobe", rdy, n == 0);
    check("tx_after_strobe", tx, n == 0);
  endtask

  task automatic pulse_ignored();
    if (rdy === 1'b0) begin
      stb   = 1'b1;
      data  = 32'h0000_00FF;
      width = 3'd1;
      @(posedge clk);
      #1;
      stb  = 1'b0;
      data = $urandom;
    end
  endtask

  initial begin
    int k;
    int trans;
    logic last_tx;
    rst   = 1'b1;
    stb   = 1'b0;
    data  = 32'h0;
    width = 3'd0;
    idle(3);
    check("reset_rdy", rdy, 1'b1);
    check("reset_tx", tx, 1'b1);
    rst = 1'b0;
    idle(2);
    check("post_reset_rdy", rdy, 1'b1);
    check("post_reset_tx", tx, 1'b1);

    send(32'h0000_00A5, 3'd1);
    send(32'h1234_5678, 3'd4);
    idle(3);
    send(32'hCAFE_F00D, 3'd0);
    send(32'hDEAD_BEEF, 3'd7);
    idle(60);
    pulse_ignored();
    idle(10);
    pulse_ignored();
    send(32'h0000_0055, 3'd1);
    send(32'h0000_00AA, 3'd1);

    for (int i = 0; i < 16; i++) begin
      send($urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, 30));
        pulse_ignored();
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
    end

    // Abort a word mid-stream during a low bit and confirm an immediate release
    send(32'h1234_5678, 3'd4);
    idle(45);
    k = 0;
    while ((tx !== 1'b0) && (k < 60)) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tx_low_before_abort", tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_tx", tx, 1'b1);
    check("rst_async_rdy", rdy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_tx", tx, 1'b1);
      check("rst_hold_rdy", rdy, 1'b1);
    end
    rst     = 1'b0;
    trans   = 0;
    last_tx = tx;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== last_tx) trans++;
      last_tx = tx;
    end
    check("tx_transitions_after_abort", trans, 0);
    check("rdy_after_abort", rdy, 1'b1);

    send(32'h0000_0081, 3'd2);
    wait_rdy();
    idle(12 * C);
    check("rdy_final", rdy, 1'b1);
    check("frames_outstanding", exp_q.size(), 0);
    check("busy_windows_outstanding", dur_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
